// File: rtl/video_timing_pkg.sv
// Shared video timing constants (800x600 @ 40 MHz pixel clock) and the
// helpers that derive sync/pulse positions from the basic H_/V_ parameters.
package video_timing_pkg;

    function automatic int unsigned sync_start_f(int unsigned visible, int unsigned fp);
        return visible + fp;
    endfunction

    function automatic int unsigned sync_end_f(int unsigned visible, int unsigned fp,
                                               int unsigned sync);
        return visible + fp + sync - 1;
    endfunction

    // Consumer registers lineActive then pixelsActive: a 2-clock lead on both edges.
    function automatic int unsigned line_start_pos_f(int unsigned h_total);
        return h_total - 2;
    endfunction

    function automatic int unsigned line_end_pos_f(int unsigned h_visible);
        return h_visible - 2;
    endfunction

    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned H_FP      = 40;
    localparam int unsigned H_SYNC    = 128;
    localparam int unsigned H_BP      = 88;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned V_FP      = 1;
    localparam int unsigned V_SYNC    = 4;
    localparam int unsigned V_BP      = 23;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned HSYNC_START    = sync_start_f(H_VISIBLE, H_FP);
    localparam int unsigned HSYNC_END      = sync_end_f(H_VISIBLE, H_FP, H_SYNC);
    localparam int unsigned VSYNC_START    = sync_start_f(V_VISIBLE, V_FP);
    localparam int unsigned VSYNC_END      = sync_end_f(V_VISIBLE, V_FP, V_SYNC);
    localparam int unsigned LINE_START_POS = line_start_pos_f(H_TOTAL);
    localparam int unsigned LINE_END_POS   = line_end_pos_f(H_VISIBLE);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } vt_state_e;

endpackage

// File: rtl/video_timing_wrap_counter.sv
// Modulo-N up counter with synchronous clear, count enable and carry-out.
// Exposes the next count so callers can decode registered outputs in step.
module wrap_counter #(
    parameter int unsigned MODULUS = 16,
    parameter int unsigned WIDTH   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_next_o,
    output logic             carry_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        carry_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                carry_o = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/video_timing.sv
// Horizontal/vertical raster timing generator. All outputs are registered and
// decoded from the counters' next values so they line up with hPos/vPos.
module video_timing #(
    parameter int unsigned H_VISIBLE = video_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = video_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = video_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = video_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE = video_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = video_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = video_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = video_timing_pkg::V_BP
) (
    input  logic        clk40,
    input  logic        rst_n,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        hsyncStarting,
    output logic        lineStarting,
    output logic        lineEnding,
    output logic        nextFrameActive,
    output logic [9:0]  nextVPos,
    output logic        frameStart,
    output logic [10:0] hPos,
    output logic [9:0]  vPos
);
    import video_timing_pkg::*;

    localparam int unsigned H_TOTAL_C = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL_C = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HS_FIRST = 11'(sync_start_f(H_VISIBLE, H_FP));
    localparam logic [10:0] HS_LAST  = 11'(sync_end_f(H_VISIBLE, H_FP, H_SYNC));
    localparam logic [9:0]  VS_FIRST = 10'(sync_start_f(V_VISIBLE, V_FP));
    localparam logic [9:0]  VS_LAST  = 10'(sync_end_f(V_VISIBLE, V_FP, V_SYNC));
    localparam logic [10:0] LS_POS   = 11'(line_start_pos_f(H_TOTAL_C));
    localparam logic [10:0] LE_POS   = 11'(line_end_pos_f(H_VISIBLE));
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL_C - 1);

    vt_state_e state_q, state_d;

    logic        h_en, cnt_clear, h_carry, v_carry, run_d;
    logic [10:0] h_cnt, h_next;
    logic [9:0]  v_cnt, v_next;

    logic       hsync_q, hsync_d, vsync_q, vsync_d, hss_q, hss_d;
    logic       ls_q, ls_d, le_q, le_d, fs_q, fs_d, nfa_q, nfa_d;
    logic [9:0] nv_q, nv_d;

    assign cnt_clear = ~enable;
    assign h_en      = enable && (state_q == ST_RUN);

    wrap_counter #(.MODULUS(H_TOTAL_C), .WIDTH(11)) u_hcount (
        .clk_i       (clk40),
        .rst_ni      (rst_n),
        .clear_i     (cnt_clear),
        .en_i        (h_en),
        .count_o     (h_cnt),
        .count_next_o(h_next),
        .carry_o     (h_carry)
    );

    wrap_counter #(.MODULUS(V_TOTAL_C), .WIDTH(10)) u_vcount (
        .clk_i       (clk40),
        .rst_ni      (rst_n),
        .clear_i     (cnt_clear),
        .en_i        (h_carry),
        .count_o     (v_cnt),
        .count_next_o(v_next),
        .carry_o     (v_carry)
    );

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = enable ? ST_RUN : ST_IDLE;
        run_d   = (state_d == ST_RUN);

        // Idle decodes as position (0,0), which already yields nextVPos=1, nextFrameActive=1.
        nv_d    = (v_next == V_LAST) ? '0 : v_next + 10'd1;
        nfa_d   = (nv_d < V_VIS);
        hsync_d = run_d && (h_next >= HS_FIRST) && (h_next <= HS_LAST);
        vsync_d = run_d && (v_next >= VS_FIRST) && (v_next <= VS_LAST);
        hss_d   = run_d && (h_next == HS_FIRST);
        ls_d    = run_d && (h_next == LS_POS) && (nv_d < V_VIS);
        le_d    = run_d && (h_next == LE_POS) && (v_next < V_VIS);
        // A frame begins either on the first enabled cycle or when the frame wraps.
        fs_d    = enable && ((state_q == ST_IDLE) || v_carry);
    end

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            hss_q   <= 1'b0;
            ls_q    <= 1'b0;
            le_q    <= 1'b0;
            fs_q    <= 1'b0;
            nfa_q   <= 1'b0;
            nv_q    <= 10'd1;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hss_q   <= hss_d;
            ls_q    <= ls_d;
            le_q    <= le_d;
            fs_q    <= fs_d;
            nfa_q   <= nfa_d;
            nv_q    <= nv_d;
        end
    end

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign hsyncStarting   = hss_q;
    assign lineStarting    = ls_q;
    assign lineEnding      = le_q;
    assign frameStart      = fs_q;
    assign nextFrameActive = nfa_q;
    assign nextVPos        = nv_q;
    assign hPos            = h_cnt;
    assign vPos            = v_cnt;

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_VISIBLE, 800, active pixels per line.
REQ-002 SHALL have parameters: H_FP 40, H_SYNC 128, H_BP 88, giving an H_TOTAL of 1056 clocks per line.
REQ-003 SHALL have parameters: V_VISIBLE 600, V_FP 1, V_SYNC 4, V_BP 23, giving a V_TOTAL of 628 lines per frame.
REQ-004 Ports SHALL be as follows; the design has one clock, and reset is asynchronous and active-low.
- clk40  in  1  pixel clock, 40 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run timing; low means hold idle.
- hsync  out  1  horizontal sync, active high.
- vsync  out  1  vertical sync, active high.
- hsyncStarting  out  1  one-cycle pulse at the first hsync cycle.
- lineStarting  out  1  one-cycle pulse 2 clocks before the first visible pixel of an active line.
- lineEnding  out  1  one-cycle pulse 2 clocks before the end of the visible region of an active line.
- nextFrameActive  out  1  the line after the current one is visible.
- nextVPos  out  10  index of the line after the current one.
- frameStart  out  1  one-cycle pulse at hPos=0, vPos=0.
- hPos  out  11  current horizontal count.
- vPos  out  10  current vertical count.

Function
REQ-005 hPos SHALL count 0..H_TOTAL-1 and wrap to 0; vPos SHALL increment when hPos wraps, and wrap 627->0.
REQ-006 Every output SHALL be registered; each output value SHALL correspond to the hPos/vPos values presented in the same cycle.
REQ-007 hsync SHALL be 1 for hPos in 840..967 inclusive.
REQ-008 vsync SHALL be 1 for vPos in 601..604 inclusive.
REQ-009 hsyncStarting SHALL be 1 only when hPos==840, on every line, including blanking lines.
REQ-010 nextVPos SHALL equal (vPos+1) mod V_TOTAL and SHALL be constant for the whole line; at vPos=627 it SHALL be 0.
REQ-011 nextFrameActive SHALL equal (nextVPos < V_VISIBLE) and SHALL be constant for the whole line.
REQ-012 lineStarting SHALL be 1 only when hPos==1054 and nextVPos<600.
- Rationale: the consumer registers lineActive and then pixelsActive, which gives a 2-cycle lead.
- Consequence: pixelsActive first goes high at hPos=0 of the next line.
REQ-013 lineEnding SHALL be 1 only when hPos==798 and vPos<600, so that exactly 800 pixels are displayed per active line.
REQ-014 frameStart SHALL be 1 only when hPos==0 and vPos==0.
REQ-015 Pulse width: every pulse SHALL be exactly one clk40 cycle.
- Consumers sampling at clk100 see each pulse for at least 2 edges; no synchronizer is provided inside this block.
REQ-016 When enable is low, the block SHALL behave as follows:
- hPos and vPos SHALL be held at 0.
- All pulses, hsync and vsync SHALL be 0.
- nextVPos SHALL be 1 and nextFrameActive SHALL be 1.
REQ-017 On the first cycle with enable high, the outputs SHALL present hPos=0, vPos=0 and frameStart=1.
REQ-018 Dropping enable mid-frame SHALL return the block to the idle state of REQ-016 at the next edge; no partial line completes.
REQ-019 Counter arithmetic SHALL be unsigned, with compares against parameter-derived constants; no output SHALL wrap except as specified.

Reset
REQ-020 While rst_n=0, the outputs SHALL take these values:
- hPos=0, vPos=0.
- hsync=0, vsync=0, all pulses 0.
- nextVPos=1, nextFrameActive=0.
REQ-021 On rst_n release, the block SHALL start from REQ-016/017 behaviour at the first clk40 edge, per the level of enable.
REQ-022 Reset asserted mid-line SHALL clear state immediately (asynchronously), with no glitch pulse on release.

Structure
REQ-023 H_/V_ constants and the derived positions SHALL live in the shared package video_timing_pkg, which the background block also uses.
- Derived positions: H_TOTAL, V_TOTAL, HSYNC_START=840, HSYNC_END=967, VSYNC_START=601, VSYNC_END=604, LINE_START_POS, LINE_END_POS.
REQ-024 The block SHALL use one sub-module, wrap_counter (parameterised modulus, enable, carry-out), instantiated once for horizontal and once for vertical counting.

Verification
REQ-025 Reset, then enable=1, run 2 frames: hsync period is 1056 clocks with high width 128; vsync period is 663168 clocks with width 4224 clocks.
REQ-026 Count lineStarting over one frame: 600 pulses, first at vPos=627/hPos=1054, last at vPos=598/hPos=1054; count lineEnding: 600 pulses.
REQ-027 Model the consumer (lineActive, then pixelsActive): pixelsActive is high for exactly 800 consecutive clocks starting at hPos=0 on each of the 600 visible lines.
REQ-028 At vPos=599: nextVPos=600 and nextFrameActive=0; at vPos=627: nextVPos=0 and nextFrameActive=1; hsyncStarting pulses on all 628 lines.
REQ-029 Toggle enable low at vPos=300/hPos=500 for 10 clocks, then high: outputs idle during low, and frameStart is asserted on the first enabled cycle.
REQ-030 Assert rst_n low asynchronously at hPos=840: hsync and hsyncStarting clear without waiting for a clock edge, and there are no pulses on release.
